// File: rtl/rv32i_fetch_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_fetch_pkg
//   Shared definitions for the RV32I instruction fetch stage: bubble
//   instruction, default reset vector, fetch FSM state encoding and a
//   word-alignment helper.
// -----------------------------------------------------------------------------
package rv32i_fetch_pkg;

  // ADDI x0,x0,0 -- the canonical RV32I no-op used as a pipeline bubble.
  localparam logic [31:0] RV32I_NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] RV32I_RESET_VEC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_STALL = 2'd2
  } fetch_state_e;

  // Instruction memory is word addressed; the low two address bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32i_fetch_hold.sv
// -----------------------------------------------------------------------------
// rv32i_fetch_hold
//   One-entry holding register for an instruction/PC pair that arrives from
//   memory while decode is stalled.
// Ports
//   clk         in   clock
//   reset       in   synchronous active-high reset
//   load        in   capture load_instr/load_pc and mark the entry valid
//   clear       in   invalidate the entry (wins over load)
//   load_instr  in   32-bit instruction to capture
//   load_pc     in   32-bit address of that instruction
//   vld         out  entry holds a valid instruction
//   hold_instr  out  captured instruction
//   hold_pc     out  captured address
// -----------------------------------------------------------------------------
module rv32i_fetch_hold (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic        vld,
  output logic [31:0] hold_instr,
  output logic [31:0] hold_pc
);

  logic        vld_reg;
  logic [31:0] instr_reg;
  logic [31:0] pc_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_reg   <= 1'b0;
      instr_reg <= 32'h0;
      pc_reg    <= 32'h0;
    end else if (clear) begin
      vld_reg   <= 1'b0;
    end else if (load) begin
      vld_reg   <= 1'b1;
      instr_reg <= load_instr;
      pc_reg    <= load_pc;
    end
  end

  assign vld        = vld_reg;
  assign hold_instr = instr_reg;
  assign hold_pc    = pc_reg;

endmodule

// File: rtl/rv32i_fetch.sv
// -----------------------------------------------------------------------------
// rv32i_fetch
//   RV32I instruction fetch stage feeding rv32i_decode. Owns the fetch PC,
//   issues word reads on a waitrequest / fixed 1-cycle-latency bus, presents
//   instr/pc_out to decode, holds them while decode stalls, redirects on
//   update_pc and fills every gap with NOP bubbles.
// Ports
//   clk            in   clock, all state on posedge
//   reset          in   synchronous active-high reset
//   iaddress       out  word-aligned read address
//   iread          out  read request
//   iwaitrequest   in   memory not accepting; request is held
//   ireaddata      in   read data, valid one cycle after an accepted read
//   update_pc      in   redirect strobe (branch/jump/trap)
//   new_pc         in   redirect target
//   stall          in   decode is not consuming instr this cycle
//   instr          out  instruction to decode
//   pc_out         out  address of instr
//   misaligned     out  one-cycle pulse: redirect target not word aligned
//   misaligned_pc  out  offending new_pc, valid with misaligned
// -----------------------------------------------------------------------------
module rv32i_fetch
  import rv32i_fetch_pkg::*;
#(
  parameter logic [31:0] RV32I_RESET_VECTOR = RV32I_RESET_VEC,
  parameter logic [31:0] RV32I_NOP          = RV32I_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] iaddress,
  output logic        iread,
  input  logic        iwaitrequest,
  input  logic [31:0] ireaddata,
  input  logic        update_pc,
  input  logic [31:0] new_pc,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic        misaligned,
  output logic [31:0] misaligned_pc
);

  fetch_state_e state_reg, state_next;

  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic        rd_pend_reg;
  logic [31:0] rd_addr_reg;
  logic        wait_hold_reg;
  logic [31:0] last_pc_reg;
  logic        misaligned_reg;
  logic [31:0] misaligned_pc_reg;

  logic [31:0] target_pc;
  logic        accept;
  logic        kill;
  logic        hold_load;
  logic        hold_clear;
  logic        hold_vld;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;

  assign target_pc = word_align(new_pc);

  // A redirect steers the bus in the same cycle, so the target read can be
  // issued without waiting for fetch_pc to update.
  assign iaddress = update_pc ? target_pc : fetch_pc_reg;

  // Reads are issued whenever decode is consuming (including the cycle a
  // stall drops, so the word after the held one arrives with no gap), on any
  // redirect, and for as long as an earlier request is still being refused
  // by memory -- a request once raised is never withdrawn under waitrequest.
  assign iread  = update_pc | ~stall | wait_hold_reg;
  assign accept = iread & ~iwaitrequest;

  // The only read that can be in flight during a redirect is the one whose
  // data returns this very cycle; it belongs to the old path.
  assign kill = update_pc;

  // Capture returning data that decode cannot take. The entry stays valid
  // until the stall releases (it is presented in that cycle) or a redirect
  // makes it stale.
  assign hold_load  = stall & rd_pend_reg & ~kill & ~hold_vld;
  assign hold_clear = update_pc | ((state_reg == FETCH_STALL) & ~stall);

  rv32i_fetch_hold u_hold (
    .clk        (clk),
    .reset      (reset),
    .load       (hold_load),
    .clear      (hold_clear),
    .load_instr (ireaddata),
    .load_pc    (rd_addr_reg),
    .vld        (hold_vld),
    .hold_instr (hold_instr),
    .hold_pc    (hold_pc)
  );

  // Next fetch PC: advance past whatever was accepted; a refused redirect
  // parks the target in fetch_pc so the request keeps pointing at it.
  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (accept) begin
      fetch_pc_next = iaddress + 32'd4;
    end else if (update_pc) begin
      fetch_pc_next = target_pc;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (update_pc) begin
      state_next = FETCH_RUN;
    end else begin
      case (state_reg)
        FETCH_BOOT:  if (accept) state_next = FETCH_RUN;
        FETCH_RUN:   if (stall)  state_next = FETCH_STALL;
        FETCH_STALL: if (!stall) state_next = FETCH_RUN;
        default:     state_next = FETCH_BOOT;
      endcase
    end
  end

  // Output mux: held word first, then fresh data, otherwise a bubble that
  // keeps the last pc_out so decode sees a stable address.
  always_comb begin
    instr  = RV32I_NOP;
    pc_out = last_pc_reg;
    if (hold_vld) begin
      instr  = hold_instr;
      pc_out = hold_pc;
    end else if (rd_pend_reg && !kill) begin
      instr  = ireaddata;
      pc_out = rd_addr_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= FETCH_BOOT;
      fetch_pc_reg      <= RV32I_RESET_VECTOR;
      rd_pend_reg       <= 1'b0;
      rd_addr_reg       <= RV32I_RESET_VECTOR;
      wait_hold_reg     <= 1'b0;
      last_pc_reg       <= RV32I_RESET_VECTOR;
      misaligned_reg    <= 1'b0;
      misaligned_pc_reg <= 32'h0;
    end else begin
      state_reg      <= state_next;
      fetch_pc_reg   <= fetch_pc_next;
      rd_pend_reg    <= accept;
      if (accept) begin
        rd_addr_reg  <= iaddress;
      end
      wait_hold_reg  <= iread & iwaitrequest;
      last_pc_reg    <= pc_out;
      misaligned_reg <= update_pc & (new_pc[1:0] != 2'b00);
      if (update_pc && (new_pc[1:0] != 2'b00)) begin
        misaligned_pc_reg <= new_pc;
      end
    end
  end

  assign misaligned    = misaligned_reg;
  assign misaligned_pc = misaligned_pc_reg;

endmodule
